// File: rtl/ysyx_25070198_dmem.sv
// Purpose : single-port on-chip data memory, SimpleBus slave behind the LSU.
// Latency : read data registered, valid 1 cycle after the address; stores land at the next edge.
// Backpressure: none; stores are accepted every cycle once mem_ready is high.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   lsu_addr      byte address, sampled every cycle (bits [1:0] ignored)
//   lsu_wen       store request
//   lsu_wdata     lane-positioned store data
//   lsu_wmask     byte-lane enables, bit i -> byte [8i+7:8i]
//   lsu_rdata     registered read data (write-first on a same-word store)
//   mem_ready     array initialised, stores accepted
//   acc_fault     one-cycle pulse after an out-of-range store
//   fault_addr    address of the most recent out-of-range store
//
// Build option: define DMEM_CLEAR_EN to include the post-reset zeroing sweep.
// Without it the memory is in RUN straight out of reset and its contents are
// undefined until written.

module ysyx_25070198_dmem #(
    parameter int unsigned ADDR_W = 10,
    parameter logic [31:0] BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic [31:0] lsu_rdata,
    output logic        mem_ready,
    output logic        acc_fault,
    output logic [31:0] fault_addr
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    // Byte span of the array, one bit wider than the address so that a
    // full 4 GiB-aligned top boundary still compares correctly.
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    // Unsigned subtraction: addresses below BASE wrap to a large offset
    // and fall out of range, so one compare covers both bounds.
    logic [31:0]       offset;
    logic              in_range;
    logic [ADDR_W-1:0] widx;

    assign offset   = lsu_addr - BASE;
    assign in_range = ({1'b0, offset} < SPAN);
    assign widx     = offset[ADDR_W+1:2];

    // ------------------------------------------------------------------
    // Sweep state machine (optional)
    // ------------------------------------------------------------------
    logic run;

`ifdef DMEM_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            if (clr_idx_q == {ADDR_W{1'b1}}) begin
                state_d = ST_RUN;
            end else begin
                clr_idx_d = clr_idx_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign run = (state_q == ST_RUN);
`else
    assign run = 1'b1;
`endif

    assign mem_ready = run;

    // ------------------------------------------------------------------
    // Array write port: sweep writes in CLEAR, LSU stores in RUN
    // ------------------------------------------------------------------
    logic [3:0]        lane_we;   // LSU store lanes actually committed
    logic [ADDR_W-1:0] wr_idx;
    logic [31:0]       wr_dat;
    logic [3:0]        wr_be;

    // Out-of-range stores and stores before RUN never reach the array.
    assign lane_we = (run && lsu_wen && in_range) ? lsu_wmask : 4'b0000;

`ifdef DMEM_CLEAR_EN
    always_comb begin
        if (state_q == ST_CLEAR) begin
            wr_idx = clr_idx_q;
            wr_dat = 32'h0;
            wr_be  = 4'b1111;
        end else begin
            wr_idx = widx;
            wr_dat = lsu_wdata;
            wr_be  = lane_we;
        end
    end
`else
    assign wr_idx = widx;
    assign wr_dat = lsu_wdata;
    assign wr_be  = lane_we;
`endif

    logic [31:0] mem_q [DEPTH];

    // Storage is deliberately not reset; the sweep (when built) zeroes it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem_q[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path: write-first merge of the stored word with this cycle's
    // store lanes, so a same-word read returns the post-store value.
    // ------------------------------------------------------------------
    logic [31:0] rd_word;
    logic [31:0] merged;
    logic [31:0] rdata_d, rdata_q;

    assign rd_word = mem_q[widx];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = lane_we[i] ? lsu_wdata[8*i +: 8] : rd_word[8*i +: 8];
        end
    end

    assign rdata_d = (run && in_range) ? merged : 32'h0;

    // ------------------------------------------------------------------
    // Fault reporting: only stores fault, and only once the array is live
    // ------------------------------------------------------------------
    logic        fault_d, fault_q;
    logic [31:0] faddr_d, faddr_q;

    assign fault_d = run && lsu_wen && !in_range;
    assign faddr_d = fault_d ? lsu_addr : faddr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
            faddr_q <= 32'h0;
        end else begin
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            faddr_q <= faddr_d;
        end
    end

    assign lsu_rdata  = rdata_q;
    assign acc_fault  = fault_q;
    assign fault_addr = faddr_q;

endmodule

// File: tb/tb_ysyx_25070198_dmem.sv
// Purpose : self-checking bench for ysyx_25070198_dmem (default parameters).
// Latency : each vector's outputs are checked 1 cycle after its inputs.
// Backpressure: n/a; stimulus issues at most one access per cycle.

module tb_ysyx_25070198_dmem;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lsu_addr;
    logic        lsu_wen;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic [31:0] lsu_rdata;
    logic        mem_ready;
    logic        acc_fault;
    logic [31:0] fault_addr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ysyx_25070198_dmem dut (
        .clk        (clk),
        .rst        (rst),
        .lsu_addr   (lsu_addr),
        .lsu_wen    (lsu_wen),
        .lsu_wdata  (lsu_wdata),
        .lsu_wmask  (lsu_wmask),
        .lsu_rdata  (lsu_rdata),
        .mem_ready  (mem_ready),
        .acc_fault  (acc_fault),
        .fault_addr (fault_addr)
    );

    typedef struct {
        string       name;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        logic [31:0] exp_faddr;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vt [NVEC];

    function automatic vec_t mk(string name, logic wen, logic [31:0] addr,
                                logic [31:0] wdata, logic [3:0] mask,
                                logic [31:0] er, logic ef, logic [31:0] efa);
        vec_t v;
        v.name = name; v.wen = wen; v.addr = addr; v.wdata = wdata; v.mask = mask;
        v.exp_rdata = er; v.exp_fault = ef; v.exp_faddr = efa;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    task automatic idle();
        lsu_wen   = 1'b0;
        lsu_addr  = 32'h8000_0000;
        lsu_wdata = 32'h0;
        lsu_wmask = 4'b0000;
    endtask

    // Drive one access just after an edge, then sample just after the next.
    task automatic access(logic wen, logic [31:0] addr, logic [31:0] wdata, logic [3:0] mask);
        lsu_wen   = wen;
        lsu_addr  = addr;
        lsu_wdata = wdata;
        lsu_wmask = mask;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        bit seen;
        bit early;

        // Stimulus table: {name, wen, addr, wdata, mask, exp rdata, exp fault, exp fault_addr}
        vt[0]  = mk("st_zero_w0",   1, 32'h8000_0000, 32'h0000_0000, 4'hF, 32'h0000_0000, 0, 32'h0);
        vt[1]  = mk("st_full_wf",   1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF, 0, 32'h0);
        vt[2]  = mk("rd_full",      0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 0, 32'h0);
        vt[3]  = mk("st_lane2",     1, 32'h8000_0010, 32'h0077_0000, 4'h4, 32'hDE77_BEEF, 0, 32'h0);
        vt[4]  = mk("rd_unaligned", 0, 32'h8000_0013, 32'h0,         4'h0, 32'hDE77_BEEF, 0, 32'h0);
        vt[5]  = mk("st_base_word", 1, 32'h8000_0020, 32'h1122_3344, 4'hF, 32'h1122_3344, 0, 32'h0);
        vt[6]  = mk("st_byte1",     1, 32'h8000_0020, 32'h0000_AB00, 4'h2, 32'h1122_AB44, 0, 32'h0);
        vt[7]  = mk("rd_merge",     0, 32'h8000_0020, 32'h0,         4'h0, 32'h1122_AB44, 0, 32'h0);
        vt[8]  = mk("st_mask0",     1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 32'h1122_AB44, 0, 32'h0);
        vt[9]  = mk("rd_mask0",     0, 32'h8000_0020, 32'h0,         4'h0, 32'h1122_AB44, 0, 32'h0);
        vt[10] = mk("st_wfirst",    1, 32'h8000_0040, 32'h5555_AAAA, 4'hF, 32'h5555_AAAA, 0, 32'h0);
        vt[11] = mk("rd_wfirst",    0, 32'h8000_0040, 32'h0,         4'h0, 32'h5555_AAAA, 0, 32'h0);
        vt[12] = mk("st_oor_top",   1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0000_0000, 1, 32'h8000_1000);
        vt[13] = mk("rd_w0_after",  0, 32'h8000_0000, 32'h0,         4'h0, 32'h0000_0000, 0, 32'h8000_1000);
        vt[14] = mk("rd_below",     0, 32'h7FFF_FFFC, 32'h0,         4'h0, 32'h0000_0000, 0, 32'h8000_1000);
        vt[15] = mk("st_last_zero", 1, 32'h8000_0FFC, 32'h0000_0000, 4'hF, 32'h0000_0000, 0, 32'h8000_1000);
        vt[16] = mk("st_last_b30",  1, 32'h8000_0FFC, 32'hA5A5_A5A5, 4'h9, 32'hA500_00A5, 0, 32'h8000_1000);
        vt[17] = mk("st_oor_below", 1, 32'h7FFF_FFFC, 32'h0000_0001, 4'hF, 32'h0000_0000, 1, 32'h7FFF_FFFC);
        vt[18] = mk("st_oor_again", 1, 32'hFFFF_FFFC, 32'h0000_0001, 4'hF, 32'h0000_0000, 1, 32'hFFFF_FFFC);
        vt[19] = mk("rd_last",      0, 32'h8000_0FFC, 32'h0,         4'h0, 32'hA500_00A5, 0, 32'hFFFF_FFFC);
        vt[20] = mk("rd_oor_top",   0, 32'h8000_1000, 32'h0,         4'h0, 32'h0000_0000, 0, 32'hFFFF_FFFC);
        vt[21] = mk("rd_w0_final",  0, 32'h8000_0000, 32'h0,         4'h0, 32'h0000_0000, 0, 32'hFFFF_FFFC);
        vt[22] = mk("rd_w4_final",  0, 32'h8000_0010, 32'h0,         4'h0, 32'hDE77_BEEF, 0, 32'hFFFF_FFFC);
        vt[23] = mk("rd_w8_final",  0, 32'h8000_0020, 32'h0,         4'h0, 32'h1122_AB44, 0, 32'hFFFF_FFFC);

        // ---------------- reset values ----------------
        idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata",  lsu_rdata,  32'h0);
        chk("rst_fault",  {31'h0, acc_fault}, 32'h0);
        chk("rst_faddr",  fault_addr, 32'h0);
`ifdef DMEM_CLEAR_EN
        chk("rst_ready",  {31'h0, mem_ready}, 32'h0);

        // ---------------- sweep interrupted at cycle 500 ----------------
        rst = 1'b0;
        early = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1;
            if (mem_ready !== 1'b0 || lsu_rdata !== 32'h0) early = 1'b1;
        end
        chk("sweep1_quiet", {31'h0, early}, 32'h0);
        rst = 1'b1;
        #1;
        chk("midrst_ready", {31'h0, mem_ready}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // ---------------- full sweep after the second release ----------------
        seen = 1'b0;
        k = 0;
        while (!seen && k < 1100) begin
            @(posedge clk);
            #1;
            k++;
            if (mem_ready === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (lsu_rdata !== 32'h0) early = 1'b1;
                // Store during CLEAR to an already-swept word must be dropped.
                if (k == 990) begin
                    lsu_wen   = 1'b1;
                    lsu_addr  = 32'h8000_0080;
                    lsu_wdata = 32'hCAFE_F00D;
                    lsu_wmask = 4'hF;
                end else begin
                    idle();
                end
            end
        end
        idle();
        chk("sweep2_rdata0", {31'h0, early}, 32'h0);
        chk("ready_cycle",   k, seen ? 32'd1024 : 32'hFFFF_FFFF);
        chk("fault_in_clear", {31'h0, acc_fault}, 32'h0);

        access(0, 32'h8000_0000, 32'h0, 4'h0);
        chk("clr_rd_first", lsu_rdata, 32'h0);
        access(0, 32'h8000_0FFC, 32'h0, 4'h0);
        chk("clr_rd_last",  lsu_rdata, 32'h0);
        access(0, 32'h8000_0080, 32'h0, 4'h0);
        chk("clr_st_drop",  lsu_rdata, 32'h0);
`else
        chk("rst_ready",  {31'h0, mem_ready}, 32'h1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_run",  {31'h0, mem_ready}, 32'h1);
`endif

        // ---------------- table-driven RUN vectors ----------------
        for (int i = 0; i < NVEC; i++) begin
            access(vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].mask);
            chk({vt[i].name, ".rdata"}, lsu_rdata, vt[i].exp_rdata);
            chk({vt[i].name, ".fault"}, {31'h0, acc_fault}, {31'h0, vt[i].exp_fault});
            chk({vt[i].name, ".faddr"}, fault_addr, vt[i].exp_faddr);
        end

        // ---------------- back-to-back stores then readback ----------------
        access(1, 32'h8000_0100, 32'h0101_0101, 4'hF);
        access(1, 32'h8000_0104, 32'h0202_0202, 4'hF);
        access(1, 32'h8000_0108, 32'h0303_0303, 4'hF);
        access(0, 32'h8000_0100, 32'h0, 4'h0);
        chk("b2b_w0", lsu_rdata, 32'h0101_0101);
        access(0, 32'h8000_0104, 32'h0, 4'h0);
        chk("b2b_w1", lsu_rdata, 32'h0202_0202);
        access(0, 32'h8000_0108, 32'h0, 4'h0);
        chk("b2b_w2", lsu_rdata, 32'h0303_0303);
        chk("ready_hold", {31'h0, mem_ready}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_25070198_dmem.md
# ysyx_25070198_dmem

On-chip data memory that serves as the SimpleBus slave directly downstream of the load/store unit. It accepts the LSU's address, write-enable, write-data and byte-mask every cycle and returns registered read data one cycle later, which is when the LSU's wait state samples it. After reset it zeroes its own array with a sweep state machine, and it reports out-of-range stores.

## Interface
Parameters:
- ADDR_W, default 10: word-address width; the array holds 2^ADDR_W 32-bit words (4 KiB at the default).
- BASE, default 32'h8000_0000: byte address of word 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- lsu_addr  in  32  byte address, driven every cycle.
- lsu_wen  in  1  store request this cycle.
- lsu_wdata  in  32  store data, already lane-positioned.
- lsu_wmask  in  4  byte-lane enables; bit i enables byte [8i+7:8i].
- lsu_rdata  out  32  registered read data.
- mem_ready  out  1  array is initialised and accepting stores.
- acc_fault  out  1  one-cycle pulse flagging an out-of-range store.
- fault_addr  out  32  address of the most recent faulting store.

## Operation
- Address decode:
  - In range when BASE <= lsu_addr < BASE + 4·2^ADDR_W.
  - Word index = (lsu_addr − BASE)[ADDR_W+1:2]; bits [1:0] are ignored for both read and write.
- The state machine has two states, CLEAR and RUN.
  - CLEAR:
    - A counter clr_idx starts at 0 and writes word clr_idx = 0, one word per cycle, incrementing.
    - On clr_idx = 2^ADDR_W−1 the state moves to RUN.
    - LSU stores are ignored and lsu_rdata is held at 0.
  - RUN:
    - Store: when lsu_wen=1 and the address is in range, only the lanes whose lsu_wmask bit is set are updated at the clock edge.
    - lsu_wmask=4'b0000 is a no-op.
- Read: every cycle in RUN, lsu_rdata is loaded with the word at the decoded index. An out-of-range address loads 0. There is no read-enable.
- Read during write to the same word is write-first: lsu_rdata receives the merged new word.
- Fault:
  - Raised when lsu_wen=1 and the address is out of range, in RUN only.
  - No array change.
  - acc_fault is 1 for exactly the next cycle, and fault_addr captures lsu_addr.
  - Out-of-range reads never fault.
- A wen held across consecutive out-of-range cycles produces one pulse per cycle, and fault_addr tracks the latest address.

## Timing
- Reset values:
  - lsu_rdata=0, acc_fault=0, fault_addr=0, clr_idx=0.
  - State = CLEAR and mem_ready=0 (the sweep is compiled in; see Configuration).
- mem_ready rises on the edge that leaves CLEAR, i.e. 2^ADDR_W cycles after rst deasserts (1024 at the default). It stays 1 until the next reset.
- Read latency is 1 cycle: the address presented in cycle N gives data on lsu_rdata throughout cycle N+1.
- Store latency is 1 cycle: a store at edge N is visible in lsu_rdata from a read addressed in cycle N+1, which appears in cycle N+2.
- Reset mid-sweep or mid-store:
  - Asynchronous return to reset values; the sweep restarts from 0.
  - Words already cleared are cleared again.
  - A partially accepted store is not guaranteed.
- Back-to-back stores are accepted every cycle. There is no stall output; the LSU must not issue before mem_ready=1.

## Configuration
- DMEM_CLEAR_EN, defined:
  - CLEAR sweep present, as described.
- DMEM_CLEAR_EN, undefined:
  - No CLEAR state and no counter.
  - Reset enters RUN directly and mem_ready=1 from reset; array contents are undefined until written.
  - All other behaviour is identical.

## Test plan
- Reset then idle: mem_ready=0 for 1024 cycles after rst falls, then 1. Afterwards, reading 0x8000_0000 and 0x8000_0FFC gives lsu_rdata=0.
- Full-word store: 0xDEADBEEF at 0x8000_0010 with mask 4'b1111, then read 0x8000_0010 → lsu_rdata=0xDEADBEEF one cycle after the read address.
- Byte merge: store 0x0000_AB00 with mask 4'b0010 over 0x1122_3344 at 0x8000_0020 → read gives 0x1122_AB44. Mask 4'b0000 leaves 0x1122_AB44 unchanged.
- Write-first: store 0x5555_AAAA to 0x8000_0040 with the read address equal in the same cycle → lsu_rdata=0x5555_AAAA in the next cycle.
- Fault: store to 0x8000_1000 → acc_fault=1 for one cycle, fault_addr=0x8000_1000, and 0x8000_0000 still reads 0. Reading 0x7FFF_FFFC gives 0 with no fault.
- Reset at cycle 500 of the sweep: mem_ready stays 0 and rises 1024 cycles after the second rst release. With DMEM_CLEAR_EN undefined, mem_ready=1 immediately after reset.
